// File: rtl/ir_pulse_capture.sv
// IR pulse capture: synchronizer, prescaled hysteresis filter, pulse duration
// counter and a first-word-fall-through token FIFO of {level, duration}.
module ir_pulse_capture #(
   parameter int unsigned PSIZE = 20,
   parameter int unsigned FSIZE = 3,
   parameter int unsigned DSIZE = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   polarity,
   input  logic [PSIZE-1:0]       prescaler,
   input  logic                   ir_in,
   output logic                   ir_filtered,
   output logic                   pulse_valid,
   input  logic                   pulse_ready,
   output logic                   pulse_level,
   output logic [DSIZE-1:0]       pulse_duration,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned TW = DSIZE + 1;
   localparam logic [FSIZE-1:0] FMAX = {FSIZE{1'b1}};
   localparam logic [DSIZE-1:0] DMAX = {DSIZE{1'b1}};
   localparam logic [LW-1:0]    FULL = LW'(DEPTH);

   // Two-flop synchronizer; keeps running while disabled
   logic sync1;
   logic sync2;
   logic sample_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= ir_in;
         sync2 <= sync1;
      end
   end

   assign sample_c = sync2 ^ polarity;

   // Tick prescaler; a reduced prescaler value wraps the count immediately
   logic [PSIZE-1:0] pcnt;
   logic             tick_c;

   assign tick_c = enable && (pcnt == prescaler);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (!enable || (pcnt >= prescaler)) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PSIZE'(1);
      end
   end

   // Hysteresis filter and duration counter next-state
   logic [FSIZE-1:0] fcnt;
   logic [FSIZE-1:0] fcnt_nxt_c;
   logic [DSIZE-1:0] dcnt;
   logic [DSIZE-1:0] dcnt_nxt_c;
   logic             filt_nxt_c;
   logic             edge_c;
   logic             timeout_c;
   logic             push_c;
   logic [TW-1:0]    token_c;

   always_comb begin
      fcnt_nxt_c = fcnt;
      filt_nxt_c = ir_filtered;
      dcnt_nxt_c = dcnt;
      edge_c     = 1'b0;
      timeout_c  = 1'b0;
      if (tick_c) begin
         if (sample_c && (fcnt != FMAX)) begin
            fcnt_nxt_c = fcnt + FSIZE'(1);
         end else if (!sample_c && (fcnt != '0)) begin
            fcnt_nxt_c = fcnt - FSIZE'(1);
         end
         if (fcnt_nxt_c == FMAX) begin
            filt_nxt_c = 1'b1;
         end else if (fcnt_nxt_c == '0) begin
            filt_nxt_c = 1'b0;
         end
         edge_c = (filt_nxt_c != ir_filtered);
         if (edge_c) begin
            dcnt_nxt_c = DSIZE'(1);
         end else if (dcnt != DMAX) begin
            dcnt_nxt_c = dcnt + DSIZE'(1);
            // Saturation is reached only once per pulse, so this fires once
            timeout_c  = (dcnt == (DMAX - DSIZE'(1)));
         end
      end
   end

   assign push_c  = edge_c || timeout_c;
   assign token_c = edge_c ? {ir_filtered, dcnt} : {ir_filtered, DMAX};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt        <= '0;
         dcnt        <= '0;
         ir_filtered <= 1'b0;
      end else if (!enable) begin
         fcnt        <= '0;
         dcnt        <= '0;
         ir_filtered <= 1'b0;
      end else begin
         fcnt        <= fcnt_nxt_c;
         dcnt        <= dcnt_nxt_c;
         ir_filtered <= filt_nxt_c;
      end
   end

   // Token FIFO control; head is precomputed so outputs come straight from flops
   logic [TW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_nxt_c;
   logic          full_c;
   logic          pop_c;
   logic          wr_c;
   logic          drop_c;
   logic [LW-1:0] level_nxt_c;
   logic [TW-1:0] head_nxt_c;

   always_comb begin
      full_c      = (fifo_level == FULL);
      pop_c       = pulse_valid && pulse_ready;
      wr_c        = push_c && (!full_c || pop_c);
      drop_c      = push_c && full_c && !pop_c;
      rd_nxt_c    = pop_c ? (rd_ptr + AW'(1)) : rd_ptr;
      level_nxt_c = fifo_level;
      if (wr_c && !pop_c) begin
         level_nxt_c = fifo_level + LW'(1);
      end else if (!wr_c && pop_c) begin
         level_nxt_c = fifo_level - LW'(1);
      end
      // A token written this cycle becomes head only if it lands in an empty queue
      if (level_nxt_c == '0) begin
         head_nxt_c = '0;
      end else if (wr_c && (rd_nxt_c == wr_ptr)) begin
         head_nxt_c = token_c;
      end else begin
         head_nxt_c = mem[rd_nxt_c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_c) begin
         mem[wr_ptr] <= token_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         fifo_level     <= '0;
         pulse_valid    <= 1'b0;
         pulse_level    <= 1'b0;
         pulse_duration <= '0;
         overflow       <= 1'b0;
      end else if (!enable) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         fifo_level     <= '0;
         pulse_valid    <= 1'b0;
         pulse_level    <= 1'b0;
         pulse_duration <= '0;
         overflow       <= 1'b0;
      end else begin
         rd_ptr                        <= rd_nxt_c;
         wr_ptr                        <= wr_c ? (wr_ptr + AW'(1)) : wr_ptr;
         fifo_level                    <= level_nxt_c;
         pulse_valid                   <= (level_nxt_c != '0);
         {pulse_level, pulse_duration} <= head_nxt_c;
         overflow                      <= drop_c;
      end
   end

endmodule
